// File: rtl/nand_seq_pkg.sv
// Shared definitions for the NAND-only sequencer: op encodings, FSM state,
// microprogram step counts and per-step operand/destination selection.
package nand_seq_pkg;

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SRC_A,
        SRC_B,
        SRC_T0,
        SRC_T1,
        SRC_T2,
        SRC_T3
    } src_t;

    typedef struct packed {
        src_t       x;
        src_t       y;
        logic [1:0] dst;
    } uop_t;

    function automatic logic [2:0] op_steps(input logic [2:0] op);
        case (op)
            OP_AND:          return 3'd2;
            OP_OR:           return 3'd3;
            OP_NOR, OP_XOR:  return 3'd4;
            OP_XNOR:         return 3'd5;
            default:         return 3'd1;
        endcase
    endfunction

    // Step numbering is zero-based; the reserved op falls through to NAND.
    function automatic uop_t op_uop(input logic [2:0] op, input logic [2:0] step);
        uop_t u;
        u = '{x: SRC_A, y: SRC_B, dst: 2'd0};
        case (op)
            OP_AND: begin
                if (step == 3'd1) u = '{x: SRC_T0, y: SRC_T0, dst: 2'd1};
            end
            OP_OR, OP_NOR: begin
                case (step)
                    3'd0:    u = '{x: SRC_A,  y: SRC_A,  dst: 2'd0};
                    3'd1:    u = '{x: SRC_B,  y: SRC_B,  dst: 2'd1};
                    3'd2:    u = '{x: SRC_T0, y: SRC_T1, dst: 2'd2};
                    default: u = '{x: SRC_T2, y: SRC_T2, dst: 2'd3};
                endcase
            end
            OP_XOR, OP_XNOR: begin
                case (step)
                    3'd0:    u = '{x: SRC_A,  y: SRC_B,  dst: 2'd0};
                    3'd1:    u = '{x: SRC_A,  y: SRC_T0, dst: 2'd1};
                    3'd2:    u = '{x: SRC_B,  y: SRC_T0, dst: 2'd2};
                    3'd3:    u = '{x: SRC_T1, y: SRC_T2, dst: 2'd3};
                    default: u = '{x: SRC_T3, y: SRC_T3, dst: 2'd0};
                endcase
            end
            OP_NOTA: u = '{x: SRC_A, y: SRC_A, dst: 2'd0};
            default: u = '{x: SRC_A, y: SRC_B, dst: 2'd0};
        endcase
        return u;
    endfunction

endpackage

// File: rtl/nand_cell.sv
// The single shared 2-input NAND evaluated once per EXEC cycle.
module nand_cell (
    input  logic a,
    input  logic b,
    output logic s
);

    assign s = ~(a & b);

endmodule

// File: rtl/nand_seq_ctrl.sv
// Two-requester round-robin controller that evaluates logic ops as NAND
// microprograms through one shared NAND cell, one step per cycle.
module nand_seq_ctrl
    import nand_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       a0,
    input  logic       b0,
    input  logic       a1,
    input  logic       b1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       done,
    output logic       s,
    output logic       done_id
);

    state_t     state_q;
    logic [2:0] step_q;
    logic       a_q;
    logic       b_q;
    logic [2:0] op_q;
    logic       id_q;
    logic       last_q;
    logic [3:0] t_q;
    logic       s_q;
    logic       done_id_q;

    logic       grant0;
    logic       grant1;
    uop_t       uop;
    logic       nand_x;
    logic       nand_y;
    logic       nand_s;
    logic       last_step;

    // last_q holds the most recent grant; resetting it to 1 favours requester 0.
    assign grant1 = req1 & (~req0 | ~last_q);
    assign grant0 = req0 & ~grant1;

    function automatic logic pick(input src_t src, input logic a, input logic b,
                                  input logic [3:0] t);
        case (src)
            SRC_A:   return a;
            SRC_B:   return b;
            SRC_T0:  return t[0];
            SRC_T1:  return t[1];
            SRC_T2:  return t[2];
            SRC_T3:  return t[3];
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        uop       = op_uop(op_q, step_q);
        nand_x    = pick(uop.x, a_q, b_q, t_q);
        nand_y    = pick(uop.y, a_q, b_q, t_q);
        last_step = (step_q == (op_steps(op_q) - 3'd1));
    end

    nand_cell u_nand (
        .a (nand_x),
        .b (nand_y),
        .s (nand_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            op_q      <= '0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            t_q       <= '0;
            s_q       <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant0 | grant1) begin
                        a_q     <= grant1 ? a1  : a0;
                        b_q     <= grant1 ? b1  : b0;
                        op_q    <= grant1 ? op1 : op0;
                        id_q    <= grant1;
                        last_q  <= grant1;
                        step_q  <= '0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    t_q[uop.dst] <= nand_s;
                    if (last_step) begin
                        s_q       <= nand_s;
                        done_id_q <= id_q;
                        state_q   <= ST_DONE;
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Acks are combinational in the IDLE cycle and suppressed while reset is asserted.
    assign ack0    = rst_n & (state_q == ST_IDLE) & grant0;
    assign ack1    = rst_n & (state_q == ST_IDLE) & grant1;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign s       = s_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_nand_seq_ctrl.sv
// Directed self-checking bench for nand_seq_ctrl with hand-computed results.
module tb_nand_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic       a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic       ack0, ack1, busy, done, s, done_id;

    int vectors;
    int miscompares;

    nand_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .op0     (op0),
        .op1     (op1),
        .ack0    (ack0),
        .ack1    (ack1),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .done_id (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Issue one request from an idle controller, scramble operands after the
    // ack, and check every cycle up to the return to IDLE.
    task automatic run_op(input logic id, input logic a, input logic b,
                          input logic [2:0] op, input logic exp_s, input int n);
        if (id) begin
            req1 = 1'b1; a1 = a; b1 = b; op1 = op;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; op0 = op;
        end
        #1;
        check("ack0_at_T", ack0, ~id);
        check("ack1_at_T", ack1, id);
        check("busy_at_T", busy, 1'b0);
        check("done_at_T", done, 1'b0);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        a0 = 1'b0; b0 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        op0 = 3'b001; op1 = 3'b001;
        for (int i = 1; i <= n; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            check("busy_exec", busy, 1'b1);
            check("done_exec", done, 1'b0);
            check("ack_exec", ack0 | ack1, 1'b0);
        end
        @(negedge clk);
        #1;
        check("done_strobe", done, 1'b1);
        check("result_s", s, exp_s);
        check("done_id", done_id, id);
        check("busy_done", busy, 1'b1);
        check("ack_in_done", ack0 | ack1, 1'b0);
        @(negedge clk);
        #1;
        check("done_cleared", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("s_held", s, exp_s);
    endtask

    initial begin
        logic [3:0] xor_exp;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 1'b0; b0 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        op0 = 3'b000; op1 = 3'b000;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_s", s, 1'b0);
        check("rst_done_id", done_id, 1'b0);
        check("rst_acks", ack0 | ack1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters held with NOR of 0,0: grants alternate, 6 cycles apart
        req0 = 1'b1; req1 = 1'b1; op0 = 3'b011; op1 = 3'b011;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("rr_ack0", ack0, (g % 2) == 0);
            check("rr_ack1", ack1, (g % 2) == 1);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                #1;
                check("rr_no_ack_busy", ack0 | ack1, 1'b0);
                check("rr_busy", busy, 1'b1);
                check("rr_done_early", done, 1'b0);
            end
            @(negedge clk);
            #1;
            check("rr_done", done, 1'b1);
            check("rr_s", s, 1'b1);
            check("rr_done_id", done_id, (g % 2) == 1);
            if (g == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            @(negedge clk);
        end
        #1;
        check("rr_end_busy", busy, 1'b0);
        check("rr_end_ack", ack0 | ack1, 1'b0);

        // NAND 1,1 on requester 0
        run_op(1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1);

        // XOR and XNOR across all operand pairs on requester 1
        xor_exp = 4'b0110;
        for (int v = 0; v < 4; v++)
            run_op(1'b1, v[1], v[0], 3'b100, xor_exp[v], 4);
        for (int v = 0; v < 4; v++)
            run_op(1'b1, v[1], v[0], 3'b101, ~xor_exp[v], 5);

        // OR 0,1 with operands changed after the ack
        run_op(1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 3);
        // AND, NOT a, NOR of 1,0, reserved op as NAND
        run_op(1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 2);
        run_op(1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 2);
        run_op(1'b1, 1'b0, 1'b1, 3'b110, 1'b1, 1);
        run_op(1'b0, 1'b1, 1'b0, 3'b011, 1'b0, 4);
        run_op(1'b1, 1'b1, 1'b0, 3'b111, 1'b1, 1);

        // Reset during the second EXEC step of an XOR aborts it
        req0 = 1'b1; a0 = 1'b1; b0 = 1'b0; op0 = 3'b100;
        #1;
        check("abort_ack0", ack0, 1'b1);
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        req1 = 1'b1; a1 = 1'b0; b1 = 1'b1; op1 = 3'b000;
        @(negedge clk);
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ack_in_reset", ack0 | ack1, 1'b0);
        check("abort_s", s, 1'b0);
        check("abort_done_id", done_id, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_done_late", done, 1'b0);
        check("post_rst_ack1", ack1, 1'b1);
        check("post_rst_ack0", ack0, 1'b0);
        @(negedge clk);
        req1 = 1'b0;
        #1;
        check("post_rst_busy", busy, 1'b1);
        check("post_rst_no_done", done, 1'b0);
        @(negedge clk);
        #1;
        check("post_rst_done", done, 1'b1);
        check("post_rst_s", s, 1'b1);
        check("post_rst_done_id", done_id, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
